// File: rtl/avalon_st_downsizer.sv
// Avalon-ST width adapter: splits each IN_SYMBOLS-wide beat into OUT_SYMBOLS-wide slices,
// preserving sop/eop framing and emitting only the slices that carry valid symbols.
module avalon_st_downsizer #(
    parameter int unsigned SYMBOL_W    = 8,
    parameter int unsigned IN_SYMBOLS  = 4,
    parameter int unsigned OUT_SYMBOLS = 2,
    parameter int unsigned IN_EMPTY_W  = (IN_SYMBOLS > 1) ? $clog2(IN_SYMBOLS) : 1,
    parameter int unsigned OUT_EMPTY_W = (OUT_SYMBOLS > 1) ? $clog2(OUT_SYMBOLS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [IN_SYMBOLS*SYMBOL_W-1:0]  snk_data_i,
    input  logic                            snk_valid_i,
    output logic                            snk_ready_o,
    input  logic                            snk_sop_i,
    input  logic                            snk_eop_i,
    input  logic [IN_EMPTY_W-1:0]           snk_empty_i,
    output logic [OUT_SYMBOLS*SYMBOL_W-1:0] src_data_o,
    output logic                            src_valid_o,
    input  logic                            src_ready_i,
    output logic                            src_sop_o,
    output logic                            src_eop_o,
    output logic [OUT_EMPTY_W-1:0]          src_empty_o
);

    localparam int unsigned RATIO = IN_SYMBOLS / OUT_SYMBOLS;
    localparam int unsigned IN_W  = IN_SYMBOLS * SYMBOL_W;
    localparam int unsigned OUT_W = OUT_SYMBOLS * SYMBOL_W;
    localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((IN_SYMBOLS % OUT_SYMBOLS) != 0) begin : g_ratio_check
        $error("IN_SYMBOLS must be a multiple of OUT_SYMBOLS");
    end

    typedef enum logic {StEmpty, StEmit} state_e;

    state_e                 state_q;
    logic [IN_W-1:0]        data_q;
    logic                   sop_q;
    logic                   eop_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       last_q;
    logic [OUT_EMPTY_W-1:0] empty_q;

    int unsigned            eff_empty;
    int unsigned            nvalid;
    int unsigned            nslices;
    logic [IDX_W-1:0]       last_d;
    logic [OUT_EMPTY_W-1:0] empty_d;
    logic [IN_W-1:0]        shifted;
    logic                   emitting;
    logic                   last_slice;
    logic                   in_acc;
    logic                   out_acc;

    // Framing of the incoming beat, resolved once at accept time.
    always_comb begin
        eff_empty = 0;
        if (snk_eop_i) begin
            eff_empty = 32'(snk_empty_i);
        end
        if (eff_empty > IN_SYMBOLS - 1) begin
            eff_empty = IN_SYMBOLS - 1;
        end
        nvalid  = IN_SYMBOLS - eff_empty;
        nslices = (nvalid + OUT_SYMBOLS - 1) / OUT_SYMBOLS;
        last_d  = IDX_W'(nslices - 1);
        empty_d = OUT_EMPTY_W'(nslices * OUT_SYMBOLS - nvalid);
    end

    always_comb begin
        emitting    = (state_q == StEmit);
        last_slice  = (idx_q == last_q);
        // Slice k sits k*OUT_W bits below the MSB of the held beat.
        shifted     = data_q << (OUT_W * 32'(idx_q));
        src_data_o  = shifted[IN_W-1 -: OUT_W];
        src_valid_o = emitting;
        src_sop_o   = emitting & sop_q & (idx_q == '0);
        src_eop_o   = emitting & eop_q & last_slice;
        src_empty_o = src_eop_o ? empty_q : '0;
        snk_ready_o = rst_n & (~emitting | (last_slice & src_ready_i));
        in_acc      = snk_valid_i & snk_ready_o;
        out_acc     = emitting & src_ready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            empty_q <= '0;
        end else begin
            if (in_acc) begin
                data_q  <= snk_data_i;
                sop_q   <= snk_sop_i;
                eop_q   <= snk_eop_i;
                last_q  <= last_d;
                empty_q <= empty_d;
            end
            unique case (state_q)
                StEmpty: begin
                    if (in_acc) begin
                        state_q <= StEmit;
                        idx_q   <= '0;
                    end
                end
                StEmit: begin
                    if (out_acc) begin
                        if (last_slice) begin
                            idx_q <= '0;
                            if (!in_acc) begin
                                state_q <= StEmpty;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_st_downsizer.sv
// Directed bench for avalon_st_downsizer: default 4->2 instance plus 8->2 and 2->2 instances.
module tb_avalon_st_downsizer;

    logic clk;
    logic rst_n;

    // Default instance (4 -> 2 symbols)
    logic [31:0] a_snk_data;
    logic        a_snk_valid, a_snk_ready, a_snk_sop, a_snk_eop;
    logic [1:0]  a_snk_empty;
    logic [15:0] a_src_data;
    logic        a_src_valid, a_src_ready, a_src_sop, a_src_eop, a_src_empty;

    // 8 -> 2 symbols
    logic [63:0] b_snk_data;
    logic        b_snk_valid, b_snk_ready, b_snk_sop, b_snk_eop;
    logic [2:0]  b_snk_empty;
    logic [15:0] b_src_data;
    logic        b_src_valid, b_src_ready, b_src_sop, b_src_eop, b_src_empty;

    // 2 -> 2 symbols (pass-through)
    logic [15:0] c_snk_data;
    logic        c_snk_valid, c_snk_ready, c_snk_sop, c_snk_eop, c_snk_empty;
    logic [15:0] c_src_data;
    logic        c_src_valid, c_src_ready, c_src_sop, c_src_eop, c_src_empty;

    avalon_st_downsizer u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .snk_data_i(a_snk_data), .snk_valid_i(a_snk_valid), .snk_ready_o(a_snk_ready),
        .snk_sop_i(a_snk_sop), .snk_eop_i(a_snk_eop), .snk_empty_i(a_snk_empty),
        .src_data_o(a_src_data), .src_valid_o(a_src_valid), .src_ready_i(a_src_ready),
        .src_sop_o(a_src_sop), .src_eop_o(a_src_eop), .src_empty_o(a_src_empty)
    );

    avalon_st_downsizer #(.SYMBOL_W(8), .IN_SYMBOLS(8), .OUT_SYMBOLS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .snk_data_i(b_snk_data), .snk_valid_i(b_snk_valid), .snk_ready_o(b_snk_ready),
        .snk_sop_i(b_snk_sop), .snk_eop_i(b_snk_eop), .snk_empty_i(b_snk_empty),
        .src_data_o(b_src_data), .src_valid_o(b_src_valid), .src_ready_i(b_src_ready),
        .src_sop_o(b_src_sop), .src_eop_o(b_src_eop), .src_empty_o(b_src_empty)
    );

    avalon_st_downsizer #(.SYMBOL_W(8), .IN_SYMBOLS(2), .OUT_SYMBOLS(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .snk_data_i(c_snk_data), .snk_valid_i(c_snk_valid), .snk_ready_o(c_snk_ready),
        .snk_sop_i(c_snk_sop), .snk_eop_i(c_snk_eop), .snk_empty_i(c_snk_empty),
        .src_data_o(c_src_data), .src_valid_o(c_src_valid), .src_ready_i(c_src_ready),
        .src_sop_o(c_src_sop), .src_eop_o(c_src_eop), .src_empty_o(c_src_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        empty;
        time         t;
    } slice_t;

    slice_t mon_q[$];

    // Record every slice the default instance hands over.
    always @(negedge clk) begin
        if (rst_n && a_src_valid && a_src_ready) begin
            mon_q.push_back('{a_src_data, a_src_sop, a_src_eop, a_src_empty, $time});
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic sop, input logic eop,
                             input logic [1:0] emp, output time t_acc);
        int waited = 0;
        a_snk_data  = d;
        a_snk_sop   = sop;
        a_snk_eop   = eop;
        a_snk_empty = emp;
        a_snk_valid = 1'b1;
        t_acc       = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!a_snk_ready && waited < 50);
        check("snk_accept_within_budget", a_snk_ready, 1);
        if (a_snk_ready) begin
            @(posedge clk);
            t_acc = $time;
            #1;
        end
        a_snk_valid = 1'b0;
    endtask

    task automatic check_slice(input int idx, input logic [15:0] d, input logic [15:0] m,
                               input logic sop, input logic eop, input logic emp);
        if (idx >= mon_q.size()) begin
            check("slice_present", 0, 1);
            return;
        end
        check("slice_data", mon_q[idx].d & m, d & m);
        check("slice_sop", mon_q[idx].sop, sop);
        check("slice_eop", mon_q[idx].eop, eop);
        check("slice_empty", mon_q[idx].empty, emp);
    endtask

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
        int          n;
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] mask;  // applies to the last slice of the beat
        logic        xe;    // expected empty on an eop slice
    } vec_t;

    vec_t vecs[7];
    time  t_acc[7];
    time  t_tmp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        vecs[0] = '{32'hA1B2C3D4, 1'b1, 1'b1, 2'd0, 2, 16'hA1B2, 16'hC3D4, 16'hFFFF, 1'b0};
        vecs[1] = '{32'h11223344, 1'b1, 1'b1, 2'd1, 2, 16'h1122, 16'h3300, 16'hFF00, 1'b1};
        vecs[2] = '{32'h11223344, 1'b1, 1'b1, 2'd2, 1, 16'h1122, 16'h0000, 16'hFFFF, 1'b0};
        vecs[3] = '{32'h11223344, 1'b1, 1'b1, 2'd3, 1, 16'h1100, 16'h0000, 16'hFF00, 1'b1};
        vecs[4] = '{32'h00010203, 1'b1, 1'b0, 2'd3, 2, 16'h0001, 16'h0203, 16'hFFFF, 1'b0};
        vecs[5] = '{32'h04050607, 1'b0, 1'b0, 2'd0, 2, 16'h0405, 16'h0607, 16'hFFFF, 1'b0};
        vecs[6] = '{32'h08090A0B, 1'b0, 1'b1, 2'd0, 2, 16'h0809, 16'h0A0B, 16'hFFFF, 1'b0};

        rst_n = 1'b0;
        a_snk_data = '0; a_snk_valid = 1'b0; a_snk_sop = 1'b0; a_snk_eop = 1'b0;
        a_snk_empty = '0; a_src_ready = 1'b0;
        b_snk_data = '0; b_snk_valid = 1'b0; b_snk_sop = 1'b0; b_snk_eop = 1'b0;
        b_snk_empty = '0; b_src_ready = 1'b1;
        c_snk_data = '0; c_snk_valid = 1'b0; c_snk_sop = 1'b0; c_snk_eop = 1'b0;
        c_snk_empty = 1'b0; c_src_ready = 1'b1;

        // Reset state
        #3;
        check("rst_src_valid", a_src_valid, 0);
        check("rst_src_sop", a_src_sop, 0);
        check("rst_src_eop", a_src_eop, 0);
        check("rst_src_empty", a_src_empty, 0);
        check("rst_snk_ready", a_snk_ready, 0);
        #9 rst_n = 1'b1;
        #1;
        check("post_rst_snk_ready", a_snk_ready, 1);
        check("post_rst_b_snk_ready", b_snk_ready, 1);

        // Table-driven beats, all back to back with the sink always ready
        @(posedge clk); #1;
        a_src_ready = 1'b1;
        mon_q.delete();
        for (int i = 0; i < 7; i++) begin
            send_beat(vecs[i].d, vecs[i].sop, vecs[i].eop, vecs[i].emp, t_acc[i]);
        end
        repeat (4) @(posedge clk);
        #1;
        check("table_slice_count", mon_q.size(), 12);
        check("pkt_beat_spacing_1", t_acc[5] - t_acc[4], 20);
        check("pkt_beat_spacing_2", t_acc[6] - t_acc[5], 20);
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                logic        is_last;
                logic [15:0] d;
                is_last = (k == vecs[i].n - 1);
                d = (k == 0) ? vecs[i].s0 : vecs[i].s1;
                check_slice(idx, d, is_last ? vecs[i].mask : 16'hFFFF,
                            (k == 0) & vecs[i].sop, is_last & vecs[i].eop,
                            is_last & vecs[i].eop & vecs[i].xe);
                if (idx < mon_q.size()) begin
                    if (k == 0) check("first_slice_latency", mon_q[idx].t - t_acc[i], 5);
                    else        check("slice_back_to_back", mon_q[idx].t - mon_q[idx-1].t, 10);
                end
                idx++;
            end
        end

        // Backpressure held for 5 cycles on the first slice of a two-beat packet
        @(posedge clk); #1;
        a_src_ready = 1'b0;
        mon_q.delete();
        send_beat(32'hCAFEBABE, 1'b1, 1'b0, 2'd0, t_tmp);
        a_snk_data = 32'hDEADBEEF; a_snk_sop = 1'b0; a_snk_eop = 1'b1; a_snk_empty = 2'd0;
        a_snk_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", a_src_valid, 1);
            check("bp_data", a_src_data, 16'hCAFE);
            check("bp_sop", a_src_sop, 1);
            check("bp_eop", a_src_eop, 0);
            check("bp_snk_ready", a_snk_ready, 0);
        end
        @(posedge clk); #1;
        a_src_ready = 1'b1;
        send_beat(32'hDEADBEEF, 1'b0, 1'b1, 2'd0, t_tmp);
        repeat (4) @(posedge clk);
        #1;
        check("bp_slice_count", mon_q.size(), 4);
        check_slice(0, 16'hCAFE, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check_slice(1, 16'hBABE, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check_slice(2, 16'hDEAD, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        check_slice(3, 16'hBEEF, 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while the second slice is pending
        @(posedge clk); #1;
        send_beat(32'h13579BDF, 1'b1, 1'b1, 2'd0, t_tmp);
        @(posedge clk); #1;
        a_src_ready = 1'b0;
        #1;
        check("pre_rst_valid", a_src_valid, 1);
        check("pre_rst_data", a_src_data, 16'h9BDF);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", a_src_valid, 0);
        check("async_rst_eop", a_src_eop, 0);
        check("async_rst_sop", a_src_sop, 0);
        check("async_rst_snk_ready", a_snk_ready, 0);
        #3 rst_n = 1'b1;
        #1;
        check("rerelease_snk_ready", a_snk_ready, 1);
        check("rerelease_valid", a_src_valid, 0);
        @(posedge clk); #1;
        a_src_ready = 1'b1;
        mon_q.delete();
        send_beat(32'h2468ACE0, 1'b1, 1'b1, 2'd0, t_tmp);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_slice_count", mon_q.size(), 2);
        check_slice(0, 16'h2468, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check_slice(1, 16'hACE0, 16'hFFFF, 1'b0, 1'b1, 1'b0);

        // 8 -> 2: eop beat with empty=5 leaves 3 valid symbols
        @(posedge clk); #1;
        b_snk_data = 64'h0102030405060708; b_snk_sop = 1'b1; b_snk_eop = 1'b1;
        b_snk_empty = 3'd5; b_snk_valid = 1'b1;
        @(negedge clk);
        check("b_snk_ready", b_snk_ready, 1);
        @(posedge clk); #1;
        b_snk_valid = 1'b0;
        @(negedge clk);
        check("b_s0_valid", b_src_valid, 1);
        check("b_s0_data", b_src_data, 16'h0102);
        check("b_s0_sop", b_src_sop, 1);
        check("b_s0_eop", b_src_eop, 0);
        @(negedge clk);
        check("b_s1_valid", b_src_valid, 1);
        check("b_s1_data", b_src_data & 16'hFF00, 16'h0300);
        check("b_s1_eop", b_src_eop, 1);
        check("b_s1_empty", b_src_empty, 1);
        @(negedge clk);
        check("b_done_valid", b_src_valid, 0);

        // 2 -> 2: registered pass-through, empty forwarded only on eop
        @(posedge clk); #1;
        c_snk_data = 16'h1234; c_snk_sop = 1'b1; c_snk_eop = 1'b0; c_snk_empty = 1'b1;
        c_snk_valid = 1'b1;
        @(negedge clk);
        check("c_snk_ready", c_snk_ready, 1);
        @(posedge clk); #1;
        c_snk_data = 16'hABCD; c_snk_sop = 1'b0; c_snk_eop = 1'b1; c_snk_empty = 1'b1;
        @(negedge clk);
        check("c_b0_valid", c_src_valid, 1);
        check("c_b0_data", c_src_data, 16'h1234);
        check("c_b0_sop", c_src_sop, 1);
        check("c_b0_empty", c_src_empty, 0);
        check("c_b0_snk_ready", c_snk_ready, 1);
        @(posedge clk); #1;
        c_snk_valid = 1'b0;
        @(negedge clk);
        check("c_b1_valid", c_src_valid, 1);
        check("c_b1_data", c_src_data & 16'hFF00, 16'hAB00);
        check("c_b1_eop", c_src_eop, 1);
        check("c_b1_empty", c_src_empty, 1);
        @(negedge clk);
        check("c_done_valid", c_src_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
